logic_basic_queue_arbiter: RTL and testbench

Round-robin, packet-aware arbiter that lets several AXI4-Stream producers share one logic_basic_queue_main instance. It sits directly in front of the queue's rx port. Once a producer wins, it keeps the grant until its tlast beat is accepted, so packets from different producers never interleave inside the queue. Each output beat carries the index of its source in tx_tid, so the queue consumer can demultiplex.

---
 rtl/logic_basic_queue_arbiter_pkg.sv | 13 +
 rtl/logic_basic_queue_arbiter_round_robin.sv | 38 +++
 rtl/logic_basic_queue_arbiter.sv | 95 +++++++++
 tb/tb_logic_basic_queue_arbiter.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/logic_basic_queue_arbiter_pkg.sv
// Shared types and helpers for the packet-aware queue arbiter.
package logic_basic_queue_arbiter_pkg;

  typedef enum logic {
    IDLE,
    LOCKED
  } state_t;

  function automatic int id_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/logic_basic_queue_arbiter_round_robin.sv
// Combinational round-robin pick starting one above the pointer.
module logic_basic_queue_arbiter_round_robin
  import logic_basic_queue_arbiter_pkg::*;
#(
  parameter  int INPUTS   = 2,
  localparam int ID_WIDTH = id_width(INPUTS)
) (
  input  logic [INPUTS-1:0]   req,
  input  logic [ID_WIDTH-1:0] ptr,
  output logic [ID_WIDTH-1:0] grant,
  output logic                valid
);

  logic [2*INPUTS-1:0] dbl;
  logic [2*INPUTS-1:0] mask;
  logic [2*INPUTS-1:0] hit;
  logic [ID_WIDTH:0]   pos;
  logic [ID_WIDTH:0]   wrapped;

  // The upper copy of req supplies the wrapped-around candidates.
  always_comb begin
    dbl = {req, req};
    for (int j = 0; j < 2*INPUTS; j++)
      mask[j] = (j > int'(ptr));
    hit = dbl & mask;
    pos = '0;
    for (int j = 2*INPUTS-1; j >= 0; j--)
      if (hit[j]) pos = (ID_WIDTH+1)'(j);
  end

  assign wrapped =
    (pos >= (ID_WIDTH+1)'(INPUTS)) ?
    pos - (ID_WIDTH+1)'(INPUTS) : pos;

  assign grant = wrapped[ID_WIDTH-1:0];
  assign valid = |req;

endmodule

// File: rtl/logic_basic_queue_arbiter.sv
// Packet-aware round-robin arbiter feeding one AXI4-Stream queue.
module logic_basic_queue_arbiter
  import logic_basic_queue_arbiter_pkg::*;
#(
  parameter  int INPUTS   = 2,
  parameter  int WIDTH    = 1,
  localparam int ID_WIDTH = id_width(INPUTS)
) (
  input  logic                         aclk,
  input  logic                         areset_n,
  input  logic [INPUTS-1:0]            rx_tvalid,
  input  logic [INPUTS-1:0]            rx_tlast,
  input  logic [INPUTS-1:0][WIDTH-1:0] rx_tdata,
  output logic [INPUTS-1:0]            rx_tready,
  input  logic                         tx_tready,
  output logic                         tx_tvalid,
  output logic                         tx_tlast,
  output logic [WIDTH-1:0]             tx_tdata,
  output logic [ID_WIDTH-1:0]          tx_tid
);

  state_t              state;
  state_t              state_n;
  logic [ID_WIDTH-1:0] ptr;
  logic [ID_WIDTH-1:0] owner;
  logic [ID_WIDTH-1:0] pick;
  logic [ID_WIDTH-1:0] cur;
  logic                pick_ok;
  logic                cur_ok;
  logic                load;
  logic                accept;
  logic                cur_last;

  logic_basic_queue_arbiter_round_robin #(
    .INPUTS(INPUTS)
  ) u_rr (
    .req  (rx_tvalid),
    .ptr  (ptr),
    .grant(pick),
    .valid(pick_ok)
  );

  assign load     = !tx_tvalid || tx_tready;
  assign cur      = (state == LOCKED) ? owner : pick;
  assign cur_ok   = (state == LOCKED) || pick_ok;
  assign accept   = rx_tvalid[cur] && rx_tready[cur];
  assign cur_last = rx_tlast[cur];

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) state <= IDLE;
    else           state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:   if (accept && !cur_last) state_n = LOCKED;
      LOCKED: if (accept &&  cur_last) state_n = IDLE;
    endcase
  end

  // No producer is acknowledged while reset is held.
  always_comb begin
    rx_tready = '0;
    if (areset_n && load && cur_ok)
      rx_tready[cur] = 1'b1;
  end

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      ptr   <= ID_WIDTH'(INPUTS-1);
      owner <= '0;
    end else if (accept) begin
      if (cur_last) ptr   <= cur;
      else          owner <= cur;
    end
  end

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      tx_tvalid <= 1'b0;
      tx_tlast  <= 1'b0;
      tx_tdata  <= '0;
      tx_tid    <= '0;
    end else if (accept) begin
      tx_tvalid <= 1'b1;
      tx_tlast  <= cur_last;
      tx_tdata  <= rx_tdata[cur];
      tx_tid    <= cur;
    end else if (tx_tready) begin
      tx_tvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_logic_basic_queue_arbiter.sv
// Randomized scoreboard bench for the queue arbiter (3 requesters).
module tb_logic_basic_queue_arbiter;

  localparam int N  = 3;
  localparam int W  = 8;
  localparam int IW = 2;

  typedef struct packed {
    logic [W-1:0] d;
    logic         l;
  } beat_t;

  typedef struct packed {
    logic [W-1:0]  d;
    logic          l;
    logic [IW-1:0] id;
  } exp_t;

  logic                aclk = 1'b0;
  logic                areset_n = 1'b0;
  logic [N-1:0]        rx_tvalid;
  logic [N-1:0]        rx_tlast;
  logic [N-1:0][W-1:0] rx_tdata;
  logic [N-1:0]        rx_tready;
  logic                tx_tready;
  logic                tx_tvalid;
  logic                tx_tlast;
  logic [W-1:0]        tx_tdata;
  logic [IW-1:0]       tx_tid;

  int    checks = 0;
  int    errors = 0;
  beat_t src[N][$];
  bit    pres[N];
  exp_t  sb[$];
  bit    m_txv;
  bit    m_lock;
  int    m_own;
  int    m_ptr;
  int    maxlen = 1;
  bit    refill = 0;

  logic_basic_queue_arbiter #(
    .INPUTS(N),
    .WIDTH (W)
  ) dut (
    .aclk     (aclk),
    .areset_n (areset_n),
    .rx_tvalid(rx_tvalid),
    .rx_tlast (rx_tlast),
    .rx_tdata (rx_tdata),
    .rx_tready(rx_tready),
    .tx_tready(tx_tready),
    .tx_tvalid(tx_tvalid),
    .tx_tlast (tx_tlast),
    .tx_tdata (tx_tdata),
    .tx_tid   (tx_tid)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string nm, input logic [31:0] a,
                     input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h t=%0t", nm, a, e, $time);
    end
  endtask

  task automatic model_reset();
    m_txv  = 0;
    m_lock = 0;
    m_own  = 0;
    m_ptr  = N - 1;
  endtask

  task automatic gen(input int i);
    int len;
    len = $urandom_range(maxlen, 1);
    for (int b = 0; b < len; b++)
      src[i].push_back('{d: W'($urandom), l: (b == len - 1)});
  endtask

  // One clock: drive producers, check ready against the model, advance it.
  task automatic cycle(input bit tr, input logic [N-1:0] allow,
                       input int dens);
    int           g;
    bit           gv;
    bit           ld;
    logic [N-1:0] want;
    @(negedge aclk);
    for (int i = 0; i < N; i++) begin
      if (refill && src[i].size() == 0) gen(i);
      if (!pres[i] && allow[i] && src[i].size() > 0 &&
          $urandom_range(99) < dens)
        pres[i] = 1;
      rx_tvalid[i] = pres[i];
      rx_tdata[i]  = pres[i] ? src[i][0].d : W'($urandom);
      rx_tlast[i]  = pres[i] ? src[i][0].l : 1'($urandom);
    end
    tx_tready = tr;
    #1;
    ld = !m_txv || tr;
    gv = 0;
    g  = 0;
    if (m_lock) begin
      g  = m_own;
      gv = 1;
    end else begin
      for (int k = 1; k <= N; k++)
        if (!gv && pres[(m_ptr + k) % N]) begin
          g  = (m_ptr + k) % N;
          gv = 1;
        end
    end
    want = '0;
    if (ld && gv) want[g] = 1'b1;
    chk("rx_tready", 32'(rx_tready), 32'(want));
    chk("tx_tvalid", 32'(tx_tvalid), 32'(m_txv));
    if (want[g] && pres[g]) begin
      sb.push_back('{d: src[g][0].d, l: src[g][0].l, id: IW'(g)});
      if (src[g][0].l) begin
        m_ptr  = g;
        m_lock = 0;
      end else begin
        m_lock = 1;
        m_own  = g;
      end
      void'(src[g].pop_front());
      pres[g] = 0;
      m_txv   = 1;
    end else if (tr) begin
      m_txv = 0;
    end
  endtask

  function automatic bit busy();
    bit b;
    b = (sb.size() > 0) || m_txv;
    for (int i = 0; i < N; i++)
      if (src[i].size() > 0) b = 1;
    return b;
  endfunction

  task automatic drain();
    int n;
    n = 0;
    refill = 0;
    while (busy() && n < 300) begin
      cycle(1'b1, '1, 100);
      n++;
    end
    chk("drain_done", 32'(n < 300), 32'd1);
  endtask

  // Monitor: pops the scoreboard on every tx handshake, checks stall holds.
  initial begin
    bit              stall;
    logic [W+IW:0]   hold;
    exp_t            e;
    stall = 0;
    hold  = '0;
    forever begin
      @(negedge aclk);
      #2;
      if (!areset_n) begin
        stall = 0;
        continue;
      end
      if (stall)
        chk("tx_stable", 32'({tx_tvalid, tx_tlast, tx_tdata, tx_tid}),
            32'({1'b1, hold}));
      if (tx_tvalid && tx_tready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL tx_unexpected got tid=%0d data=%0h want none",
                   tx_tid, tx_tdata);
        end else begin
          e = sb.pop_front();
          chk("tx_beat", 32'({tx_tdata, tx_tlast, tx_tid}),
              32'({e.d, e.l, e.id}));
        end
      end
      stall = tx_tvalid && !tx_tready;
      hold  = {tx_tlast, tx_tdata, tx_tid};
    end
  end

  initial begin
    model_reset();
    for (int i = 0; i < N; i++) pres[i] = 0;
    rx_tvalid = '0;
    rx_tlast  = '0;
    rx_tdata  = '0;
    tx_tready = 1'b0;

    repeat (3) begin
      @(negedge aclk);
      rx_tvalid = N'($urandom);
      rx_tlast  = N'($urandom);
      rx_tdata  = {N{W'($urandom)}};
      tx_tready = 1'($urandom);
      #1;
      chk("rst_rx_tready", 32'(rx_tready), 32'd0);
      chk("rst_tx_tvalid", 32'(tx_tvalid), 32'd0);
      chk("rst_tx_tid", 32'(tx_tid), 32'd0);
    end
    rx_tvalid = '0;
    @(negedge aclk);
    areset_n = 1'b1;

    // Single-beat packets from 0 and 1 alternate, one per cycle.
    refill = 1;
    maxlen = 1;
    repeat (20) cycle(1'b1, 3'b011, 100);
    drain();

    // 4-beat packet from 1; requester 0 joins at beat 2 and must wait.
    for (int b = 0; b < 4; b++)
      src[1].push_back('{d: W'(8'hA1 + b), l: (b == 3)});
    src[0].push_back('{d: 8'h55, l: 1'b1});
    cycle(1'b1, 3'b010, 100);
    repeat (6) cycle(1'b1, 3'b011, 100);
    drain();

    // Random packets, random back-pressure, all requesters.
    refill = 1;
    maxlen = 5;
    repeat (2000) cycle(1'($urandom_range(1)), '1, 70);
    drain();

    // Only the top requester: grant must wrap back to index 2.
    refill = 1;
    maxlen = 3;
    repeat (200) cycle(1'b1, 3'b100, 100);
    drain();

    // Reset in the middle of a locked packet from requester 1.
    for (int b = 0; b < 4; b++)
      src[1].push_back('{d: W'(8'hB1 + b), l: (b == 3)});
    src[0].push_back('{d: 8'h66, l: 1'b1});
    cycle(1'b1, 3'b010, 100);
    cycle(1'b1, 3'b011, 100);
    @(posedge aclk);
    #3 areset_n = 1'b0;
    #1;
    chk("arst_tx_tvalid", 32'(tx_tvalid), 32'd0);
    chk("arst_tx_tlast", 32'(tx_tlast), 32'd0);
    chk("arst_tx_tdata", 32'(tx_tdata), 32'd0);
    chk("arst_tx_tid", 32'(tx_tid), 32'd0);
    chk("arst_rx_tready", 32'(rx_tready), 32'd0);
    model_reset();
    sb.delete();
    repeat (2) @(posedge aclk);
    #3 areset_n = 1'b1;
    cycle(1'b1, 3'b011, 100);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
